// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART Tx mux select codes and Tx FSM state encoding
package uart_pkg;

    // Tx output mux select codes, shared with the Tx mux
    localparam logic [2:0] SEL_START   = 3'd0;
    localparam logic [2:0] SEL_STOP    = 3'd1;
    localparam logic [2:0] SEL_PARITY  = 3'd2;
    localparam logic [2:0] SEL_SHIFTER = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Line source that each state presents on the Tx mux
    function automatic logic [2:0] sel_for_state(input tx_state_t s);
        case (s)
            ST_START:  return SEL_START;
            ST_DATA:   return SEL_SHIFTER;
            ST_PARITY: return SEL_PARITY;
            default:   return SEL_STOP;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - baud-rate counter with synchronous clear and bit-end tick
module uart_baud_gen #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(BAUD_DIV - 1));

    // Count 0..BAUD_DIV-1 while enabled; held at zero when idle or cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit sequencing FSM driving Tx mux and shifter strobes
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic [2:0]           mux_sel,
    output logic                 mux_en,
    output logic                 shift_load,
    output logic                 shift_en,
    output logic                 tx_parity
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       ODD       = 1'(PARITY_ODD);

    tx_state_t  state, state_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic       stop_cnt, stop_cnt_next;
    logic       shift_load_next, shift_en_next, done_next, parity_next;
    logic       tick, baud_clr, baud_en;

    assign baud_en = (state != ST_IDLE);

    uart_baud_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (baud_clr),
        .en  (baud_en),
        .tick(tick)
    );

    // Next state, counters and strobe values; a new frame may start from IDLE
    // or directly on the final stop tick so back-to-back frames have no gap
    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        stop_cnt_next   = stop_cnt;
        shift_load_next = 1'b0;
        shift_en_next   = 1'b0;
        done_next       = 1'b0;
        parity_next     = tx_parity;
        baud_clr        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    state_next      = ST_START;
                    shift_load_next = 1'b1;
                    parity_next     = ^tx_data ^ ODD;
                    baud_clr        = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt < LAST_BIT) begin
                        shift_en_next = 1'b1;
                        bit_cnt_next  = bit_cnt + 3'd1;
                    end else begin
                        stop_cnt_next = 1'b0;
                        state_next    = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_next    = ST_STOP;
                    stop_cnt_next = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        done_next = 1'b1;
                        if (tx_start) begin
                            state_next      = ST_START;
                            shift_load_next = 1'b1;
                            parity_next     = ^tx_data ^ ODD;
                            baud_clr        = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_next = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and all outputs registered together so mux_sel tracks the state exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            stop_cnt   <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            mux_sel    <= SEL_STOP;
            mux_en     <= 1'b0;
            shift_load <= 1'b0;
            shift_en   <= 1'b0;
            tx_parity  <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            stop_cnt   <= stop_cnt_next;
            tx_busy    <= (state_next != ST_IDLE);
            tx_done    <= done_next;
            mux_sel    <= sel_for_state(state_next);
            mux_en     <= 1'b1;
            shift_load <= shift_load_next;
            shift_en   <= shift_en_next;
            tx_parity  <= parity_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl across three configurations
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst_s   [3];
    logic       start_s [3];
    logic [7:0] data_s  [3];
    logic       busy_s  [3];
    logic       done_s  [3];
    logic [2:0] sel_s   [3];
    logic       en_s    [3];
    logic       load_s  [3];
    logic       shen_s  [3];
    logic       par_s   [3];

    int checks = 0;
    int errors = 0;

    // dut 0: BAUD 4, even parity, 1 stop; dut 1: BAUD 4, no parity, 2 stop;
    // dut 2: BAUD 2, odd parity, 1 stop
    uart_tx_ctrl #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst_s[0]), .tx_start(start_s[0]), .tx_data(data_s[0]),
        .tx_busy(busy_s[0]), .tx_done(done_s[0]), .mux_sel(sel_s[0]), .mux_en(en_s[0]),
        .shift_load(load_s[0]), .shift_en(shen_s[0]), .tx_parity(par_s[0]));

    uart_tx_ctrl #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst_s[1]), .tx_start(start_s[1]), .tx_data(data_s[1]),
        .tx_busy(busy_s[1]), .tx_done(done_s[1]), .mux_sel(sel_s[1]), .mux_en(en_s[1]),
        .shift_load(load_s[1]), .shift_en(shen_s[1]), .tx_parity(par_s[1]));

    uart_tx_ctrl #(.BAUD_DIV(2), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(rst_s[2]), .tx_start(start_s[2]), .tx_data(data_s[2]),
        .tx_busy(busy_s[2]), .tx_done(done_s[2]), .mux_sel(sel_s[2]), .mux_en(en_s[2]),
        .shift_load(load_s[2]), .shift_en(shen_s[2]), .tx_parity(par_s[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int baud_of(input int w);
        return (w == 2) ? 2 : 4;
    endfunction

    function automatic int par_en_of(input int w);
        return (w == 1) ? 0 : 1;
    endfunction

    function automatic int odd_of(input int w);
        return (w == 2) ? 1 : 0;
    endfunction

    function automatic int stop_of(input int w);
        return (w == 1) ? 2 : 1;
    endfunction

    // Reference: frame is a list of bit slots START, 8 x DATA, [PARITY], STOP...
    // each BAUD clks; k counts clks since the accepting edge
    function automatic int exp_sel(input int w, input int k);
        int b;
        b = k / baud_of(w);
        if (b == 0) return 0;
        if (b <= 8) return 3;
        if (par_en_of(w) != 0 && b == 9) return 2;
        return 1;
    endfunction

    // Shift strobe appears at the start of data slots 2..8 (none after the last bit)
    function automatic int exp_shen(input int w, input int k);
        int b;
        b = k / baud_of(w);
        return ((k % baud_of(w)) == 0 && b >= 2 && b <= 8) ? 1 : 0;
    endfunction

    function automatic int frame_len(input int w);
        return (1 + 8 + par_en_of(w) + stop_of(w)) * baud_of(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input int w, input string tag);
        chk($sformatf("%s busy[%0d]", tag, w), 32'(busy_s[w]), 0);
        chk($sformatf("%s done[%0d]", tag, w), 32'(done_s[w]), 0);
        chk($sformatf("%s sel[%0d]", tag, w), 32'(sel_s[w]), 1);
        chk($sformatf("%s mux_en[%0d]", tag, w), 32'(en_s[w]), 0);
        chk($sformatf("%s load[%0d]", tag, w), 32'(load_s[w]), 0);
        chk($sformatf("%s shen[%0d]", tag, w), 32'(shen_s[w]), 0);
        chk($sformatf("%s parity[%0d]", tag, w), 32'(par_s[w]), 0);
    endtask

    task automatic launch(input int w, input logic [7:0] d);
        @(negedge clk);
        data_s[w]  = d;
        start_s[w] = 1'b1;
        @(posedge clk);
    endtask

    // Walk one frame clk by clk from the accepting edge, comparing against the model
    task automatic frame_check(input int w, input logic [7:0] d, input bit hold,
                               input bit prev_done, input bit poke);
        int len, bd;
        logic [31:0] par_exp;
        len = frame_len(w);
        bd = baud_of(w);
        par_exp = 32'((^d) ^ odd_of(w));
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) start_s[w] = 1'b0;
            if (poke && k == bd * 4) begin
                start_s[w] = 1'b1;
                data_s[w]  = ~d;
            end
            if (poke && k == bd * 4 + 1) start_s[w] = 1'b0;
            chk($sformatf("sel[%0d] k=%0d", w, k), 32'(sel_s[w]), 32'(exp_sel(w, k)));
            chk($sformatf("load[%0d] k=%0d", w, k), 32'(load_s[w]), (k == 0) ? 1 : 0);
            chk($sformatf("shen[%0d] k=%0d", w, k), 32'(shen_s[w]), 32'(exp_shen(w, k)));
            chk($sformatf("busy[%0d] k=%0d", w, k), 32'(busy_s[w]), 1);
            chk($sformatf("done[%0d] k=%0d", w, k), 32'(done_s[w]), (k == 0) ? 32'(prev_done) : 0);
            chk($sformatf("parity[%0d] k=%0d", w, k), 32'(par_s[w]), par_exp);
            chk($sformatf("mux_en[%0d] k=%0d", w, k), 32'(en_s[w]), 1);
        end
        if (!hold) begin
            @(negedge clk);
            chk($sformatf("end done[%0d]", w), 32'(done_s[w]), 1);
            chk($sformatf("end busy[%0d]", w), 32'(busy_s[w]), 0);
            chk($sformatf("end sel[%0d]", w), 32'(sel_s[w]), 1);
            chk($sformatf("end load[%0d]", w), 32'(load_s[w]), 0);
            chk($sformatf("end parity[%0d]", w), 32'(par_s[w]), par_exp);
            @(negedge clk);
            chk($sformatf("idle done[%0d]", w), 32'(done_s[w]), 0);
            chk($sformatf("idle busy[%0d]", w), 32'(busy_s[w]), 0);
            chk($sformatf("idle sel[%0d]", w), 32'(sel_s[w]), 1);
        end
    endtask

    initial begin
        logic [7:0] d, d2;
        for (int w = 0; w < 3; w++) begin
            rst_s[w]   = 1'b1;
            start_s[w] = 1'b0;
            data_s[w]  = 8'h00;
        end
        #1;
        for (int w = 0; w < 3; w++) chk_reset_vals(w, "reset");

        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) rst_s[w] = 1'b0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("idle busy[%0d]", w), 32'(busy_s[w]), 0);
            chk($sformatf("idle sel[%0d]", w), 32'(sel_s[w]), 1);
            chk($sformatf("idle mux_en[%0d]", w), 32'(en_s[w]), 1);
            chk($sformatf("idle load[%0d]", w), 32'(load_s[w]), 0);
        end

        // Even parity frame of 8'hA5
        launch(0, 8'hA5);
        frame_check(0, 8'hA5, 1'b0, 1'b0, 1'b0);

        // Randomized single frames on the parity configuration
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            launch(0, d);
            frame_check(0, d, 1'b0, 1'b0, 1'b0);
        end

        // No parity, two stop bits
        launch(1, 8'h01);
        frame_check(1, 8'h01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            launch(1, d);
            frame_check(1, d, 1'b0, 1'b0, 1'b0);
        end

        // tx_start held high: back-to-back frames with no idle gap
        d  = 8'($urandom);
        d2 = 8'($urandom);
        launch(0, d);
        frame_check(0, d, 1'b1, 1'b0, 1'b0);
        data_s[0] = d2;
        frame_check(0, d2, 1'b0, 1'b1, 1'b0);

        d  = 8'($urandom);
        d2 = ~d;
        launch(1, d);
        frame_check(1, d, 1'b1, 1'b0, 1'b0);
        data_s[1] = d2;
        frame_check(1, d2, 1'b0, 1'b1, 1'b0);

        // tx_start pulsed mid-DATA is ignored
        d = 8'($urandom);
        launch(0, d);
        frame_check(0, d, 1'b0, 1'b0, 1'b1);

        // Reset mid-DATA aborts the frame without tx_done
        d = 8'($urandom);
        launch(0, d);
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre-reset sel", 32'(sel_s[0]), 3);
        #2;
        rst_s[0] = 1'b1;
        #1;
        chk_reset_vals(0, "midreset");
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk($sformatf("in-reset done k=%0d", i), 32'(done_s[0]), 0);
        end
        rst_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk($sformatf("post-reset done k=%0d", i), 32'(done_s[0]), 0);
            chk($sformatf("post-reset busy k=%0d", i), 32'(busy_s[0]), 0);
        end
        d = 8'($urandom);
        launch(0, d);
        frame_check(0, d, 1'b0, 1'b0, 1'b0);

        // Odd parity, BAUD_DIV=2
        launch(2, 8'hFF);
        frame_check(2, 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            launch(2, d);
            frame_check(2, d, 1'b0, 1'b0, 1'b0);
        end
        d  = 8'($urandom);
        d2 = 8'($urandom);
        launch(2, d);
        frame_check(2, d, 1'b1, 1'b0, 1'b0);
        data_s[2] = d2;
        frame_check(2, d2, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
